// File: rtl/udc_pkg.sv
// Shared encodings for the nRISC multi-cycle control unit: FSM states,
// opcodes, ALU operation and mux select codes.
package udc_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_EXEC_I = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_MEM_WR = 4'd7,
        S_WB_R   = 4'd8,
        S_WB_I   = 4'd9,
        S_WB_MEM = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

    localparam logic [2:0] OP_R    = 3'd0;
    localparam logic [2:0] OP_LW   = 3'd1;
    localparam logic [2:0] OP_SW   = 3'd2;
    localparam logic [2:0] OP_BEQ  = 3'd3;
    localparam logic [2:0] OP_ADDI = 3'd4;
    localparam logic [2:0] OP_JMP  = 3'd7;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;
    localparam logic [1:0] ALU_ADDI  = 2'd3;

    localparam logic [1:0] SRCB_RT  = 2'd0;
    localparam logic [1:0] SRCB_ONE = 2'd1;
    localparam logic [1:0] SRCB_IMM = 2'd2;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/udc_output_decode.sv
// Combinational state -> datapath control decode (Moore, except the FETCH
// PC/IR loads which wait for mem_ready). Optional UDC_ILLEGAL_TRAP_EN adds the illegal flag.
module udc_output_decode
    import udc_pkg::*;
#(
    parameter int ALU_OP_W = 2
) (
    input  state_t              state,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic [1:0]          pc_source,
    output logic                ir_write,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op
`ifdef UDC_ILLEGAL_TRAP_EN
    ,
    output logic                illegal
`endif
);

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PCSRC_ALU;
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_RT;
        alu_op        = ALU_OP_W'(ALU_ADD);
`ifdef UDC_ILLEGAL_TRAP_EN
        illegal       = 1'b0;
`endif
        case (state)
            S_FETCH: begin
                // PC+1 and IR load only commit once the fetch read completes
                mem_read  = 1'b1;
                alu_src_b = SRCB_ONE;
                pc_write  = mem_ready;
                ir_write  = mem_ready;
            end
            S_DECODE: alu_src_b = SRCB_IMM;
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_OP_W'(ALU_FUNCT);
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_OP_W'(ALU_ADDI);
            end
            S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_WB_R: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_WB_I:   reg_write = 1'b1;
            S_WB_MEM: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_OP_W'(ALU_SUB);
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
`ifdef UDC_ILLEGAL_TRAP_EN
            S_TRAP:   illegal = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/udc_multiciclo.sv
// Multi-cycle control unit for the nRISC datapath: state register, next-state
// logic and retired-instruction counter. Define UDC_ILLEGAL_TRAP_EN to trap on illegal opcodes.
module udc_multiciclo
    import udc_pkg::*;
#(
    parameter int OPCODE_W = 3,
    parameter int ALU_OP_W = 2,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    input  logic                zero,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic [1:0]          pc_source,
    output logic                ir_write,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [3:0]          state_o,
    output logic [CNT_W-1:0]    instr_count
`ifdef UDC_ILLEGAL_TRAP_EN
    ,
    output logic                illegal
`endif
);

    state_t     state, state_nxt;
    logic       retire;
    logic [2:0] op_low;
    logic       op_legal;
    logic       unused_zero;

    // zero is consumed by the datapath's conditional PC load, not by sequencing
    assign unused_zero = zero;

    assign op_low   = opcode[2:0];
    assign op_legal = ((opcode >> 3) == '0) &&
                      (op_low inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_JMP});

    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        case (state)
            S_IDLE:   if (run) state_nxt = S_FETCH;
            S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                if (!op_legal) begin
`ifdef UDC_ILLEGAL_TRAP_EN
                    state_nxt = S_TRAP;
`else
                    state_nxt = S_FETCH;
                    retire    = 1'b1;
`endif
                end else begin
                    case (op_low)
                        OP_R:         state_nxt = S_EXEC_R;
                        OP_LW, OP_SW: state_nxt = S_ADDR;
                        OP_BEQ:       state_nxt = S_BRANCH;
                        OP_ADDI:      state_nxt = S_EXEC_I;
                        default:      state_nxt = S_JUMP;
                    endcase
                end
            end
            S_EXEC_R: state_nxt = S_WB_R;
            S_EXEC_I: state_nxt = S_WB_I;
            S_ADDR:   state_nxt = (op_low == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: if (mem_ready) state_nxt = S_WB_MEM;
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_nxt = S_FETCH;
                    retire    = 1'b1;
                end
            end
            S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: begin
                state_nxt = S_FETCH;
                retire    = 1'b1;
            end
            S_TRAP:   state_nxt = S_TRAP;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            instr_count <= '0;
        end else begin
            state <= state_nxt;
            if (retire) instr_count <= instr_count + 1'b1;
        end
    end

    assign state_o = state;

    udc_output_decode #(
        .ALU_OP_W(ALU_OP_W)
    ) u_output_decode (
        .state         (state),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .ir_write      (ir_write),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op)
`ifdef UDC_ILLEGAL_TRAP_EN
        ,
        .illegal       (illegal)
`endif
    );

endmodule
